// File: rtl/io_pwm_cap_pkg.sv
// Shared types and register map for the PWM input-capture core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

    localparam int STATUS_ADDR = 0;
    localparam int EN_ADDR     = 1;
    localparam int LEVEL_ADDR  = 2;
    localparam int CAP_BASE    = 16;
    localparam int OVF_LSB     = 16;

endpackage

// File: rtl/io_pwm_cap_core_chan.sv
// One capture channel: pin synchronizer, edge detect, phase FSM, counter and capture registers.
// Latency: pin to s2 in 2 edges; captures and set pulses land on the 3rd edge.
// Backpressure: none; free-running, set pulses are single-cycle and must be absorbed by the caller.
module pwm_cap_chan
    import io_pwm_cap_pkg::*;
#(
    parameter int C = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         pwm_in,
    output logic         level,
    output logic [C-1:0] high,
    output logic [C-1:0] period,
    output logic         valid_set,
    output logic         ovf_set
);

    localparam logic [C-1:0] CNT_MAX = '1;
    localparam logic [C-1:0] ONE     = {{(C-1){1'b0}}, 1'b1};

    logic         s1, s2, s3;
    logic         rise, fall;
    cap_state_t   state, state_nxt;
    logic [C-1:0] cnt;
    logic [C-1:0] cnt_sat1;
    logic         cnt_clr, cnt_inc, lat_high, lat_period;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign level    = s2;
    // Saturating cnt+1: used both to advance the counter and as the latched width
    assign cnt_sat1 = (cnt == CNT_MAX) ? CNT_MAX : cnt + ONE;

    // Two-stage synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Phase state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Phase transitions; disabling always returns to IDLE so a fresh rise is needed
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (rise) state_nxt = HIGH;
                HIGH:    if (fall) state_nxt = LOW;
                LOW:     if (rise) state_nxt = HIGH;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath controls; the counter keeps running across the falling edge so period spans rise to rise
    always_comb begin
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        lat_high   = 1'b0;
        lat_period = 1'b0;
        valid_set  = 1'b0;
        ovf_set    = 1'b0;
        if (!en) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) cnt_clr = 1'b1;
                end
                HIGH: begin
                    cnt_inc  = 1'b1;
                    lat_high = fall;
                    ovf_set  = (cnt == CNT_MAX);
                end
                LOW: begin
                    ovf_set = (cnt == CNT_MAX);
                    if (rise) begin
                        lat_period = 1'b1;
                        valid_set  = 1'b1;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    // Counter and capture registers; captures hold while the channel is disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            high   <= '0;
            period <= '0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt_sat1;
            if (lat_high)     high   <= cnt_sat1;
            if (lat_period)   period <= cnt_sat1;
        end
    end

endmodule

// File: rtl/io_pwm_cap_core.sv
// PWM input-capture slot: W capture channels behind status/enable/level/capture registers.
// Latency: register writes act at the write edge; rd_data is combinational from addr.
// Backpressure: none; the slot always accepts accesses and reads have no side effects.
module io_pwm_cap_core
    import io_pwm_cap_pkg::*;
#(
    parameter int W = 4,
    parameter int C = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] pwm_in
);

    logic [W-1:0] valid_q, ovf_q, en_q;
    logic [W-1:0] level, valid_set, ovf_set;
    logic [C-1:0] high_a   [W];
    logic [C-1:0] period_a [W];
    logic         status_we, en_we;
    logic [W-1:0] valid_clr, ovf_clr;
    logic         unused_bits;

    assign status_we   = write && cs && (int'(addr) == STATUS_ADDR);
    assign en_we       = write && cs && (int'(addr) == EN_ADDR);
    assign valid_clr   = status_we ? wr_data[W-1:0] : '0;
    assign ovf_clr     = status_we ? wr_data[OVF_LSB +: W] : '0;
    // Read strobe and upper write bits carry no meaning here
    assign unused_bits = ^{read, wr_data};

    for (genvar i = 0; i < W; i++) begin : g_chan
        pwm_cap_chan #(.C(C)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .en        (en_q[i]),
            .pwm_in    (pwm_in[i]),
            .level     (level[i]),
            .high      (high_a[i]),
            .period    (period_a[i]),
            .valid_set (valid_set[i]),
            .ovf_set   (ovf_set[i])
        );
    end

    // Sticky flags with W1C; a hardware set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            valid_q <= (valid_q & ~valid_clr) | valid_set;
            ovf_q   <= (ovf_q & ~ovf_clr) | ovf_set;
        end
    end

    // Channel enable register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     en_q <= '0;
        else if (en_we) en_q <= wr_data[W-1:0];
    end

    // Read mux; unmapped addresses and absent channels read as zero
    always_comb begin
        rd_data = '0;
        if (int'(addr) == STATUS_ADDR) begin
            rd_data[W-1:0]         = valid_q;
            rd_data[OVF_LSB +: W]  = ovf_q;
        end else if (int'(addr) == EN_ADDR) begin
            rd_data[W-1:0] = en_q;
        end else if (int'(addr) == LEVEL_ADDR) begin
            rd_data[W-1:0] = level;
        end
        for (int i = 0; i < W; i++) begin
            if (int'(addr) == CAP_BASE + 2*i)     rd_data[C-1:0] = high_a[i];
            if (int'(addr) == CAP_BASE + 2*i + 1) rd_data[C-1:0] = period_a[i];
        end
    end

endmodule

// File: doc/io_pwm_cap_core.md
# io_pwm_cap_core

PWM input-capture core on the standard MMIO slot interface; the measuring counterpart of the PWM output core. Each of W channels synchronizes an external pulse train, counts clock cycles between edges and latches high time and period for software readback. It lets firmware read back PWM waveforms (loopback self-test, fan tach, servo feedback) through the same bus slot style as the other io cores.

## Interface
- `W`, 4: number of capture channels, 1..8.
- `C`, 32: counter and capture width in bits, 8..32.
- `clk` in 1: system clock.
- `reset` in 1: reset, one clock; reset is asynchronous and active-low.
- `cs` in 1: slot select.
- `read` in 1: read strobe; informational only, reads have no side effects.
- `write` in 1: write strobe.
- `addr` in 5: word address within slot.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data, combinational from `addr`.
- `pwm_in` in W: asynchronous external pulse inputs.

## Operation
- Register map:
  - addr 0, status: bits[W-1:0] `valid`, bits[16+W-1:16] `ovf`. Write is write-1-to-clear on those bits.
  - addr 1, enable: bits[W-1:0] are R/W enables.
  - addr 2, level: bits[W-1:0] are read-only synchronized input levels.
  - addr 16+2i, high[i]: read-only, zero-extended.
  - addr 17+2i, period[i]: read-only, zero-extended.
  - Unmapped reads return 0.
- Write decode: `write && cs && addr == 0` for status, `write && cs && addr == 1` for enable. Writes elsewhere are ignored.
- Per channel front end: 2-FF synchronizer `s1`, `s2`, plus delay FF `s3`. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- Per channel FSM, states IDLE, HIGH, LOW:
  - Disabled: forced to IDLE, `cnt` = 0. Capture registers and flags hold.
  - IDLE: `rise` moves to HIGH and sets `cnt` <= 0. `fall` is ignored.
  - HIGH: `fall` latches `high` <= sat(`cnt`+1) and moves to LOW. `rise` cannot occur.
  - LOW: `rise` latches `period` <= sat(`cnt`+1), sets `valid`, sets `cnt` <= 0 and moves to HIGH.
  - In HIGH and LOW, `cnt` increments every cycle without an edge and saturates at 2^C-1.
- Width rule: a signal high H cycles with period P reads back `high` = H and `period` = P.
- Saturation:
  - When `cnt` reaches 2^C-1 in HIGH or LOW, `ovf` is set (sticky).
  - A latch from a saturated `cnt` stores 2^C-1.
  - A stuck input leaves `valid` unchanged but sets `ovf`.
- Flag priority: a hardware set and a W1C clear in the same cycle leave the flag set.
- Clearing the enable bit mid-measurement discards the partial count. Re-enabling waits for a fresh rising edge.
- Reset values: all FSMs IDLE, `cnt`/`high`/`period` = 0, `valid` = `ovf` = 0, enable = 0, sync FFs 0, `rd_data` = 0 for addr 0.

## Timing
- Pin to `s2`: 2 edges. Edge pulse is combinational from `s2`/`s3`.
- Captured value, `valid` and `ovf` are visible on `rd_data` 3 clk edges after the first edge that samples the new pin level.
- Minimum resolvable high or low phase: 1 cycle. Shorter pulses may be missed and are not flagged.
- Status/enable writes take effect at the write edge and read back on the next cycle.
- `rd_data` has zero read latency: combinational on `addr`, independent of `read`.

## Structure
- Package `io_pwm_cap_pkg`:
  - `cap_state_t` enum (IDLE, HIGH, LOW).
  - Address constants `STATUS_ADDR` = 0, `EN_ADDR` = 1, `LEVEL_ADDR` = 2, `CAP_BASE` = 16.
  - `OVF_LSB` = 16.
- Sub-module `pwm_cap_chan`: one channel containing synchronizer, edge detect, FSM, counter and capture registers. Parameter C. Ports: `en`, `pwm_in`, `level`, `high`, `period`, `valid_set`, `ovf_set`.
- Top level: generate loop over W channels, slot decode, status and enable registers, read mux.

## Test plan
- Reset, then enable ch0 and drive H = 3, P = 10 for 5 periods -> `high[0]` = 3, `period[0]` = 10, `valid[0]` = 1, `ovf` = 0.
- Enable all 4 channels with duties 1/4, 5/8, 7/12, 2/3 -> each `high[i]`/`period[i]` correct and independent. Write 0xF to addr 0 -> `valid` = 0, then it reasserts after the next period.
- C = 8, input held high 300 cycles -> `ovf[0]` = 1 and `valid[0]` = 0. The subsequent fall latches `high` = 255.
- Issue the W1C of `valid[1]` on the same cycle ch1 latches a period -> `valid[1]` reads 1.
- Disable ch2 mid-HIGH, re-enable and feed H = 4, P = 9 -> first result is 4/9 and the old partial count is discarded. Assert `reset` low mid-run -> every register reads 0 immediately.
- Input held low while enabled -> `valid` = 0, `ovf` = 0 (IDLE does not count), `level` = 0.
